// File: rtl/next_pc_seq_if.sv
// Request/response bundle between the MIPS32 core control and the PC unit.
// The core drives requests through the master modport; the PC unit is the slave.
interface next_pc_seq_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EPC_DEPTH = 4
);
    localparam int unsigned DW = $clog2(EPC_DEPTH + 1);

    logic             i_stall;
    logic [25:0]      i_Imm26;
    logic [WIDTH-1:0] i_Rs;
    logic             i_Zero;
    logic             i_Beq;
    logic             i_Bne;
    logic             i_J;
    logic             i_Jr;
    logic             i_exception;
    logic             i_eret;

    logic [WIDTH-1:0] o_PC;
    logic [WIDTH-1:0] o_PC_4;
    logic [WIDTH-1:0] o_epc;
    logic [DW-1:0]    o_epc_depth;
    logic             o_epc_ovf;
    logic             o_epc_unf;
    logic             o_addr_err;

    modport master (
        output i_stall, i_Imm26, i_Rs, i_Zero, i_Beq, i_Bne, i_J, i_Jr,
               i_exception, i_eret,
        input  o_PC, o_PC_4, o_epc, o_epc_depth, o_epc_ovf, o_epc_unf, o_addr_err
    );

    modport slave (
        input  i_stall, i_Imm26, i_Rs, i_Zero, i_Beq, i_Bne, i_J, i_Jr,
               i_exception, i_eret,
        output o_PC, o_PC_4, o_epc, o_epc_depth, o_epc_ovf, o_epc_unf, o_addr_err
    );
endinterface

// File: rtl/next_pc_seq.sv
// Registered program counter for the unpipelined MIPS32 core.
// Selects the next PC from eret / exception / Jr / J / branch requests and
// keeps a private EPC stack so nested exceptions return in LIFO order.
module next_pc_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned EXC_VECTOR = 12,
    parameter int unsigned EPC_DEPTH  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    next_pc_seq_if.slave bus
);
    localparam int unsigned DW = $clog2(EPC_DEPTH + 1);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_4;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] stack [EPC_DEPTH];
    logic [DW-1:0]    depth;
    logic             ovf;
    logic             unf;
    logic             addr_err;

    logic empty;
    logic full;
    logic branch_take;
    logic jr_misaligned;
    logic do_push;
    logic do_pop;
    logic set_ovf;
    logic set_unf;
    logic set_addr_err;

    assign pc_4          = {pc[WIDTH-1:2] + (WIDTH-2)'(1), 2'b00};
    assign br_target     = pc_4 + {{(WIDTH-18){bus.i_Imm26[15]}}, bus.i_Imm26[15:0], 2'b00};
    assign branch_take   = (bus.i_Beq & bus.i_Zero) | (bus.i_Bne & ~bus.i_Zero);
    assign jr_misaligned = bus.i_Jr & (bus.i_Rs[1:0] != 2'b00);
    assign empty         = (depth == '0);
    assign full          = (depth == DW'(EPC_DEPTH));

    // At 28 bits the jump target is entirely the immediate; no PC region bits remain.
    generate
        if (WIDTH == 28) begin : g_jump_narrow
            assign j_target = {bus.i_Imm26, 2'b00};
        end else begin : g_jump_wide
            assign j_target = {pc_4[WIDTH-1:28], bus.i_Imm26, 2'b00};
        end
    endgenerate

    // Top-of-stack view: entry[depth-1], or zero when the stack is empty.
    always_comb begin
        epc = '0;
        for (int unsigned k = 0; k < EPC_DEPTH; k++) begin
            if (depth == DW'(k + 1)) epc = stack[k];
        end
    end

    // Next-PC priority select and stack/flag side effects.
    always_comb begin
        next_pc      = pc_4;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        set_ovf      = 1'b0;
        set_unf      = 1'b0;
        set_addr_err = 1'b0;
        if (bus.i_eret) begin
            if (!empty) begin
                next_pc = epc;
                do_pop  = 1'b1;
            end else begin
                set_unf = 1'b1;
            end
        end else if (bus.i_exception || jr_misaligned) begin
            // A misaligned Jr traps like an exception; addr_err only flags the Jr cause.
            next_pc      = WIDTH'(EXC_VECTOR);
            set_addr_err = ~bus.i_exception;
            if (full) set_ovf = 1'b1;
            else      do_push = 1'b1;
        end else if (bus.i_Jr) begin
            next_pc = bus.i_Rs;
        end else if (bus.i_J) begin
            next_pc = j_target;
        end else if (branch_take) begin
            next_pc = br_target;
        end
    end

    // PC, EPC stack and status registers; stall freezes everything but addr_err.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc       <= WIDTH'(RESET_PC);
            depth    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            addr_err <= 1'b0;
            for (int unsigned k = 0; k < EPC_DEPTH; k++) stack[k] <= '0;
        end else if (bus.i_stall) begin
            addr_err <= 1'b0;
        end else begin
            pc       <= next_pc;
            addr_err <= set_addr_err;
            if (set_ovf) ovf <= 1'b1;
            if (set_unf) unf <= 1'b1;
            if (do_push) begin
                depth <= depth + DW'(1);
                for (int unsigned k = 0; k < EPC_DEPTH; k++) begin
                    if (depth == DW'(k)) stack[k] <= pc;
                end
            end else if (do_pop) begin
                depth <= depth - DW'(1);
            end
        end
    end

    assign bus.o_PC        = pc;
    assign bus.o_PC_4      = pc_4;
    assign bus.o_epc       = epc;
    assign bus.o_epc_depth = depth;
    assign bus.o_epc_ovf   = ovf;
    assign bus.o_epc_unf   = unf;
    assign bus.o_addr_err  = addr_err;
endmodule
